// File: rtl/id_exe_pipe.sv
// ID/EXE pipeline register with EXE/MEM operand forwarding and load-use hazard detection.
// A load in EXE feeding the ID instruction stalls PC and IF/ID for one cycle and bubbles EXE.
module id_exe_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        dwreg,
  input  logic        dm2reg,
  input  logic        dwmem,
  input  logic        daluimm,
  input  logic        dshift,
  input  logic [2:0]  daluc,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic [4:0]  drn,
  input  logic        drs_used,
  input  logic        drt_used,
  input  logic [31:0] dqa,
  input  logic [31:0] dqb,
  input  logic [31:0] dimm,
  input  logic        dflush,
  input  logic [31:0] ealu_fb,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic [4:0]  mrn,
  input  logic [31:0] malu,
  input  logic [31:0] mmo,
  output logic        ewreg,
  output logic        em2reg,
  output logic        ewmem,
  output logic        ealuimm,
  output logic        eshift,
  output logic [2:0]  ealuc,
  output logic [4:0]  ern,
  output logic [31:0] ea,
  output logic [31:0] eb,
  output logic [31:0] eimm,
  output logic        stall
);

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        aluimm;
    logic        shift;
    logic [2:0]  aluc;
    logic [4:0]  rn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } exe_t;

  exe_t exe_q, exe_d;
  logic [31:0] fwd_a, fwd_b;
  logic        hz, bubble;

  // EXE wins over MEM because it holds the younger write; a load in EXE has no data yet.
  function automatic logic [31:0] forward(input logic [4:0] rs, input logic [31:0] rf_val,
                                          input exe_t ex, input logic [31:0] alu_fb,
                                          input logic m_wreg, input logic m_m2reg,
                                          input logic [4:0] m_rn, input logic [31:0] m_alu,
                                          input logic [31:0] m_mo);
    if (ex.wreg && !ex.m2reg && ex.rn != 5'd0 && ex.rn == rs)
      return alu_fb;
    else if (m_wreg && m_rn != 5'd0 && m_rn == rs)
      return m_m2reg ? m_mo : m_alu;
    else
      return rf_val;
  endfunction

  always_comb begin
    fwd_a = forward(drs, dqa, exe_q, ealu_fb, mwreg, mm2reg, mrn, malu, mmo);
    fwd_b = forward(drt, dqb, exe_q, ealu_fb, mwreg, mm2reg, mrn, malu, mmo);
  end

  assign hz = exe_q.wreg & exe_q.m2reg & (exe_q.rn != 5'd0) &
              ((drs_used & (exe_q.rn == drs)) | (drt_used & (exe_q.rn == drt)));
  assign stall  = hz & ~dflush;
  assign bubble = hz | dflush;

  always_comb begin
    // NOTE: default first so every path assigns exe_d and no latch is inferred.
    exe_d = '0;
    if (!bubble) begin
      exe_d.wreg   = dwreg;
      exe_d.m2reg  = dm2reg;
      exe_d.wmem   = dwmem;
      exe_d.aluimm = daluimm;
      exe_d.shift  = dshift;
      exe_d.aluc   = daluc;
      exe_d.rn     = drn;
      exe_d.a      = fwd_a;
      exe_d.b      = fwd_b;
      exe_d.imm    = dimm;
    end
  end

  // NOTE: non-blocking assignment for registered state avoids simulation races between processes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) exe_q <= '0;
    else     exe_q <= exe_d;
  end

  assign ewreg   = exe_q.wreg;
  assign em2reg  = exe_q.m2reg;
  assign ewmem   = exe_q.wmem;
  assign ealuimm = exe_q.aluimm;
  assign eshift  = exe_q.shift;
  assign ealuc   = exe_q.aluc;
  assign ern     = exe_q.rn;
  assign ea      = exe_q.a;
  assign eb      = exe_q.b;
  assign eimm    = exe_q.imm;

endmodule

// File: tb/tb_id_exe_pipe.sv
// Directed bench for id_exe_pipe: reset, forwarding priority, load-use stall, flush, async reset.
module tb_id_exe_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        dwreg, dm2reg, dwmem, daluimm, dshift;
  logic [2:0]  daluc;
  logic [4:0]  drs, drt, drn;
  logic        drs_used, drt_used;
  logic [31:0] dqa, dqb, dimm;
  logic        dflush;
  logic [31:0] ealu_fb;
  logic        mwreg, mm2reg;
  logic [4:0]  mrn;
  logic [31:0] malu, mmo;
  logic        ewreg, em2reg, ewmem, ealuimm, eshift;
  logic [2:0]  ealuc;
  logic [4:0]  ern;
  logic [31:0] ea, eb, eimm;
  logic        stall;

  int checks = 0;
  int errors = 0;

  id_exe_pipe dut (
    .clk(clk), .rst(rst),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm), .dshift(dshift),
    .daluc(daluc), .drs(drs), .drt(drt), .drn(drn),
    .drs_used(drs_used), .drt_used(drt_used),
    .dqa(dqa), .dqb(dqb), .dimm(dimm), .dflush(dflush),
    .ealu_fb(ealu_fb), .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
    .malu(malu), .mmo(mmo),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm), .eshift(eshift),
    .ealuc(ealuc), .ern(ern), .ea(ea), .eb(eb), .eimm(eimm), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    dwreg = 0; dm2reg = 0; dwmem = 0; daluimm = 0; dshift = 0; daluc = 3'd0;
    drs = 0; drt = 0; drn = 0; drs_used = 0; drt_used = 0;
    dqa = 0; dqb = 0; dimm = 0; dflush = 0;
  endtask

  task automatic clear_mem();
    mwreg = 0; mm2reg = 0; mrn = 0; malu = 0; mmo = 0;
  endtask

  // Put a load to r8 into EXE (no forwarding sources elsewhere).
  task automatic load_r8_into_exe();
    clear_id(); clear_mem();
    dwreg = 1; dm2reg = 1; drn = 5'd8;
    step();
  endtask

  initial begin
    clear_id(); clear_mem(); ealu_fb = 0;
    rst = 1;
    dwreg = 1; drn = 5'd5; dqa = 32'd7; dqb = 32'd9; dimm = 32'h3C;
    step();
    check("rst_ewreg", ewreg, 0);
    check("rst_ern",   ern,   0);
    check("rst_ea",    ea,    0);
    check("rst_eimm",  eimm,  0);
    check("rst_stall", stall, 0);

    // Plain capture, no hazards.
    rst = 0;
    clear_id();
    dwreg = 1; drn = 5'd5; daluc = 3'b010; dqa = 32'd7; dqb = 32'd9; dimm = 32'h3C;
    daluimm = 1; dshift = 1;
    step();
    check("cap_ewreg", ewreg, 1);
    check("cap_ern",   ern,   5);
    check("cap_ealuc", ealuc, 3'b010);
    check("cap_ea",    ea,    7);
    check("cap_eb",    eb,    9);
    check("cap_eimm",  eimm,  32'h3C);
    check("cap_aluimm_shift", {ealuimm, eshift}, 2'b11);

    // EXE -> ID forward from ALU op to r3.
    clear_id(); dwreg = 1; drn = 5'd3;
    step();
    clear_id(); drs = 5'd3; drs_used = 1; dqa = 0; drn = 5'd6; dwreg = 1;
    ealu_fb = 32'h1234;
    #1 check("exe_fwd_nostall", stall, 0);
    step();
    check("exe_fwd_ea", ea, 32'h1234);

    // r0 is never forwarded.
    clear_id(); dwreg = 1; drn = 5'd0;
    step();
    clear_id(); drs = 5'd0; drs_used = 1; dqa = 32'h11;
    step();
    check("r0_no_fwd_ea", ea, 32'h11);

    // MEM -> ID forward on B, load data then ALU data.
    clear_id();
    step();
    mwreg = 1; mm2reg = 1; mrn = 5'd4; mmo = 32'hAA; malu = 32'h55;
    clear_id(); drt = 5'd4; drt_used = 1; dqb = 0;
    step();
    check("mem_fwd_mmo_eb", eb, 32'hAA);
    mm2reg = 0;
    dwreg = 1; drn = 5'd4;
    step();
    check("mem_fwd_malu_eb", eb, 32'h55);
    // EXE now writes r4 as well; the younger EXE value wins.
    ealu_fb = 32'h77; dwreg = 0; drn = 0;
    step();
    check("exe_over_mem_eb", eb, 32'h77);

    // Load-use on rs: one bubble, then forward from MEM load data.
    load_r8_into_exe();
    clear_id(); drs = 5'd8; drs_used = 1; dwreg = 1; drn = 5'd9; daluc = 3'd1; dqa = 0;
    #1 check("lu_stall", stall, 1);
    step();
    check("lu_bubble_ctl", {ewreg, em2reg, ewmem}, 3'b000);
    check("lu_bubble_ern", ern, 0);
    mwreg = 1; mm2reg = 1; mrn = 5'd8; mmo = 32'hBEEF;
    #1 check("lu_stall_drop", stall, 0);
    step();
    check("lu_after_ea",    ea,    32'hBEEF);
    check("lu_after_ern",   ern,   9);
    check("lu_after_ewreg", ewreg, 1);

    // Same dependency but rs not actually read: no stall.
    load_r8_into_exe();
    clear_id(); drs = 5'd8; drs_used = 0; dwreg = 1; drn = 5'd9; dqa = 32'h42;
    #1 check("nouse_stall", stall, 0);
    step();
    check("nouse_ewreg", ewreg, 1);
    check("nouse_ea",    ea,    32'h42);

    // Flush dominates the hazard: no stall, bubble enters EXE.
    load_r8_into_exe();
    clear_id(); drs = 5'd8; drs_used = 1; dwreg = 1; drn = 5'd9; dflush = 1;
    #1 check("flush_stall", stall, 0);
    step();
    check("flush_ewreg", ewreg, 0);
    check("flush_ern",   ern,   0);

    // Load-use via rt, then asynchronous reset between edges.
    load_r8_into_exe();
    clear_id(); drt = 5'd8; drt_used = 1; dwreg = 1; drn = 5'd9;
    #1 check("rt_stall", stall, 1);
    #1 rst = 1;
    #1;
    check("arst_ctl",   {ewreg, em2reg, ewmem}, 3'b000);
    check("arst_ern",   ern,   0);
    check("arst_stall", stall, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
